// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format parameters, status codes and the converter state enum.
package fpu_pkg;

    // Result format {sign, exponent[EXP_W-1:0], mantissa[MAN_W-1:0]}, hidden leading 1
    localparam int unsigned BIAS  = 31;
    localparam int unsigned EXP_W = 6;
    localparam int unsigned MAN_W = 25;

    // Status codes; only EXACT and INEXACT are produced by int_to_fp
    localparam logic [3:0] EXACT     = 4'b0001;
    localparam logic [3:0] OVERFLOW  = 4'b0011;
    localparam logic [3:0] UNDERFLOW = 4'b0111;
    localparam logic [3:0] INEXACT   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

endpackage

// File: rtl/int_to_fp.sv
// Sequential signed 32-bit integer to floating-point converter.
// The magnitude is normalised one bit per cycle, then truncated into the
// mantissa field; discarded bits only raise the inexact status.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - request conversion of int_in (sampled only in IDLE)
//   int_in     - two's-complement operand
//   data_out   - {sign, exponent, mantissa}, held between done pulses
//   status_out - EXACT or INEXACT, held between done pulses
//   busy       - high while a conversion is in progress (NORM, PACK)
//   done       - one-cycle pulse when data_out/status_out update
module int_to_fp #(
    parameter int unsigned BIAS  = fpu_pkg::BIAS,
    parameter int unsigned EXP_W = fpu_pkg::EXP_W,
    parameter int unsigned MAN_W = fpu_pkg::MAN_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out,
    output logic        busy,
    output logic        done
);

    import fpu_pkg::*;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [31:0]        mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         status_q, status_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        data_d   = data_q;
        status_d = status_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = int_in[31];
                    // Negating -2^31 wraps back to 0x80000000, which is the correct magnitude
                    mag_d   = int_in[31] ? 32'(-int_in) : int_in;
                    exp_d   = EXP_W'(BIAS + 31);
                    state_d = NORM;
                end
            end
            NORM: begin
                if ((mag_q == 32'd0) || mag_q[31]) begin
                    state_d = PACK;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            PACK: begin
                if (mag_q == 32'd0) begin
                    // Zero has its own all-zero encoding rather than 1.0 x 2^(exp-BIAS)
                    data_d   = 32'd0;
                    status_d = EXACT;
                end else begin
                    data_d   = {sign_q, exp_q, mag_q[30 -: MAN_W]};
                    status_d = (|mag_q[30-MAN_W:0]) ? INEXACT : EXACT;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= 32'd0;
            exp_q    <= '0;
            data_q   <= 32'd0;
            status_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            data_q   <= data_d;
            status_q <= status_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data_out   = data_q;
    assign status_out = status_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed corner values, held start,
// mid-conversion reset, then randomized operands against an arithmetic model.
module tb_int_to_fp;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] int_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expectation state shared between driver and compare process
    int          exp_start = -1000;
    int          exp_lat   = 0;
    logic [31:0] nxt_data  = 32'd0;
    logic [3:0]  nxt_status = 4'd0;
    logic [31:0] exp_data  = 32'd0;
    logic [3:0]  exp_status = 4'd0;

    int_to_fp dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .int_in     (int_in),
        .data_out   (data_out),
        .status_out (status_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    // Value-level model: normalise by locating the top set bit, truncate the fraction
    function automatic void model(input logic [31:0] x, output logic [31:0] d,
                                  output logic [3:0] s, output int lat);
        longint m, frac, mant, e, dl;
        int     p;
        bit     inexact;
        m = x[31] ? ((longint'(1) << 32) - longint'(x)) : longint'(x);
        if (m == 0) begin
            d = 32'd0; s = 4'b0001; lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++)
            if (m >= (longint'(1) << i)) p = i;
        frac = m - (longint'(1) << p);
        e    = 31 + p;
        if (p >= 25) begin
            mant    = frac >> (p - 25);
            inexact = (frac % (longint'(1) << (p - 25))) != 0;
        end else begin
            mant    = frac << (25 - p);
            inexact = 1'b0;
        end
        dl  = (longint'(x[31]) << 31) + (e << 25) + mant;
        d   = 32'(dl);
        s   = inexact ? 4'b1111 : 4'b0001;
        lat = 31 - p + 2;
    endfunction

    // Cycle-by-cycle comparison of every output against the expectation
    always @(negedge clock) begin
        bit e_busy, e_done;
        e_busy = (cyc >= exp_start) && (cyc < exp_start + exp_lat);
        e_done = (cyc == exp_start + exp_lat);
        if (e_done) begin
            exp_data   = nxt_data;
            exp_status = nxt_status;
        end
        chk("done",       32'(done),       32'(e_done));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("data_out",   data_out,        exp_data);
        chk("status_out", 32'(status_out), 32'(exp_status));
    end

    // One conversion; optionally releases reset in the same step as start,
    // optionally holds start high through to the done edge
    task automatic do_conv(input logic [31:0] x, input bit hold, input bit rel);
        logic [31:0] d;
        logic [3:0]  s;
        int          l;
        model(x, d, s, l);
        @(posedge clock); #1;
        if (rel) reset = 1'b0;
        start      = 1'b1;
        int_in     = x;
        exp_start  = cyc + 1;
        exp_lat    = l;
        nxt_data   = d;
        nxt_status = s;
        @(posedge clock); #1;
        if (!hold) begin
            start  = 1'b0;
            int_in = $urandom;
        end
        repeat (l) @(posedge clock);
        #1;
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clock);
    endtask

    task automatic pin(input logic [31:0] x, input logic [31:0] wd,
                       input logic [3:0] ws, input int wl);
        logic [31:0] d;
        logic [3:0]  s;
        int          l;
        model(x, d, s, l);
        chk("model_data",   d,          wd);
        chk("model_status", 32'(s),     32'(ws));
        chk("model_lat",    32'(l),     32'(wl));
    endtask

    initial begin
        logic [31:0] x;
        reset  = 1'b1;
        start  = 1'b0;
        int_in = 32'd0;

        pin(32'd1,          32'h3E00_0000, 4'b0001, 33);
        pin(32'hFFFF_FFFD,  32'hC100_0000, 4'b0001, 32);
        pin(32'h7FFF_FFFF,  32'h7BFF_FFFF, 4'b1111, 3);
        pin(32'h8000_0000,  32'hFC00_0000, 4'b0001, 2);
        pin(32'd0,          32'h0000_0000, 4'b0001, 2);

        repeat (2) @(posedge clock);

        // First edge after reset release samples start
        do_conv(32'd1,         1'b0, 1'b1);
        do_conv(32'hFFFF_FFFD, 1'b0, 1'b0);
        do_conv(32'h7FFF_FFFF, 1'b0, 1'b0);
        do_conv(32'h8000_0000, 1'b0, 1'b0);
        do_conv(32'd0,         1'b0, 1'b0);
        do_conv(32'hFFFF_FFFF, 1'b0, 1'b0);

        // start held high across a whole conversion
        do_conv(32'd1,         1'b1, 1'b0);
        do_conv(32'h0000_0041, 1'b1, 1'b0);

        // Reset ten cycles into a conversion of 1
        @(posedge clock); #1;
        start      = 1'b1;
        int_in     = 32'd1;
        exp_start  = cyc + 1;
        exp_lat    = 33;
        nxt_data   = 32'h3E00_0000;
        nxt_status = 4'b0001;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset      = 1'b1;
        exp_start  = -1000;
        exp_data   = 32'd0;
        exp_status = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);

        // Randomized operands spanning all leading-zero counts and both signs
        for (int n = 0; n < 40; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = 32'(-x);
            do_conv(x, 1'($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (3) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
